cla_serial_subtractor: RTL
==========================

# cla_serial_subtractor

Multi-cycle WIDTH-bit subtractor computing diff = a − b − bin. It processes one 4-bit nibble per clock through a single 4-bit carry-look-ahead slice and keeps the borrow in a register between nibbles. It is the subtract counterpart of the team's 4-bit CLA adder. It serves datapaths that need wide subtraction without a full-width borrow chain and can tolerate NIBBLES cycles of latency behind a start/done handshake.

## Interface
- WIDTH, 16: operand width in bits. Must be a multiple of 4 and at least 4.
- NIBBLES, WIDTH/4: derived; number of processing cycles. Not to be overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous and active-high.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on an accepted start.
- b  input  WIDTH  subtrahend; captured on an accepted start.
- bin  input  1  borrow-in; captured on an accepted start.
- busy  output  1  high while nibbles are being processed.
- done  output  1  one-cycle pulse when diff/bout/ovf have just been updated.
- diff  output  WIDTH  result a − b − bin, modulo 2^WIDTH.
- bout  output  1  borrow-out. 1 iff unsigned a < b + bin.
- ovf  output  1  signed (two's-complement) overflow of the subtraction.

## Operation
- States:
  - IDLE → RUN on start=1; captures a, b and bin, and clears the nibble counter.
  - RUN → RUN while counter < NIBBLES−1.
  - RUN → DONE on the edge that processes the last nibble.
  - DONE → IDLE unconditionally.
- Per RUN cycle, for nibble i (LSB first, i = 0..NIBBLES−1):
  - {c, s} = a[4i+3:4i] + ~b[4i+3:4i] + ~borrow, computed with 4-bit CLA generate/propagate logic.
  - Store s in result bits [4i+3:4i]; next borrow = ~c.
  - The borrow register is initialised to bin.
- Result staging: an internal register holds the partial result. diff/bout/ovf update only on the edge that processes the last nibble, so partial results never appear on the outputs.
- ovf = (a[WIDTH−1] != b[WIDTH−1]) && (diff[WIDTH−1] != a[WIDTH−1]). It uses the captured operands and ignores bin.
- Outputs diff/bout/ovf hold their last values until the next completion. Start and reset are the only other influences; start does not clear them.
- start while in RUN or DONE is ignored (not queued). Input changes after capture have no effect.
- Reset values: state IDLE, busy 0, done 0, diff 0, bout 0, ovf 0, counter 0, borrow 0.
- Reset asserted mid-operation aborts immediately. The result is discarded, outputs take their reset values, and no done pulse is issued.

## Timing
- Edge E0 samples start=1 in IDLE. busy is 1 from after E0 through edge E(NIBBLES). Nibbles are processed on edges E1..E(NIBBLES).
- done is 1 for exactly one cycle after E(NIBBLES), with busy=0 in the same cycle. diff/bout/ovf are valid from that cycle onward.
- Latency from the start-sampling edge to done is NIBBLES cycles; this is 4 for WIDTH=16.
- Minimum issue interval is NIBBLES+2 cycles, because the DONE cycle is followed by IDLE. Holding start=1 continuously launches a new operation every NIBBLES+2 cycles.
- busy and done are never high together. done is never high for two consecutive cycles.
- WIDTH=4 case: one RUN cycle, with done in the cycle after it.

## Test plan
- 0x1234 − 0x0234, bin=0 → diff=0x1000, bout=0, ovf=0. done exactly 4 cycles after the start edge, and busy high for those 4 cycles.
- 0x0000 − 0x0001, bin=0 → diff=0xFFFF, bout=1, ovf=0. The borrow must ripple through all 4 nibbles.
- 0x8000 − 0x0001 → diff=0x7FFF, bout=0, ovf=1. Then 0x7FFF − 0xFFFF → diff=0x8000, bout=1, ovf=1.
- 0x0005 − 0x0005, bin=1 → diff=0xFFFF, bout=1, ovf=0. Also 0xABCD − 0xABCD, bin=0 → 0x0000, bout=0.
- Start 0x0010 − 0x0001, then pulse start with different a/b and change a/b during busy → result still 0x000F with a single done pulse. The second start is ignored, and outputs hold 0x000F until the next accepted start completes.
- Assert rst asynchronously (between clock edges) in the second RUN cycle → busy, done, diff, bout and ovf drop to 0 immediately, and no done pulse follows. A new start after rst deasserts completes normally with the correct result.

Source files
------------

// File: rtl/cla_serial_subtractor_if.sv
// Handshake and operand/result bundle for the nibble-serial subtractor.
// The master issues start with its operands, and the slave returns busy, done and the result.
interface cla_serial_subtractor_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout, ovf
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout, ovf
  );
endinterface

// File: rtl/cla_serial_subtractor.sv
// Multi-cycle subtractor: diff = a - b - bin, one nibble per clock through a
// single 4-bit carry-look-ahead slice, LSB nibble first. The borrow lives in a
// register between nibbles. The outputs change only when the last nibble completes.
module cla_serial_subtractor #(
  parameter int WIDTH   = 16,
  parameter int NIBBLES = WIDTH / 4
) (
  input logic                   clk,
  input logic                   rst,
  cla_serial_subtractor_if.slave bus
);

  localparam int CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             borrow_reg;
  // The operands shift right by a nibble each RUN cycle, so the active nibble is always [3:0].
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  // The sign bits are kept apart because the shifting operands lose them before the overflow check.
  logic             a_msb_reg;
  logic             b_msb_reg;
  // The partial result fills from the top. After the last nibble it holds the full difference.
  logic [WIDTH-1:0] res_reg;
  logic [WIDTH-1:0] diff_reg;
  logic             bout_reg;
  logic             ovf_reg;
  logic             busy_reg;
  logic             done_reg;

  // CLA slice signals. Subtraction is done as a + ~b + ~borrow.
  logic [3:0]       nib_a;
  logic [3:0]       nib_nb;
  logic [3:0]       gen;
  logic [3:0]       prop;
  logic [4:0]       carry;
  logic [3:0]       nib_sum;
  logic [WIDTH+3:0] res_cat;
  logic [WIDTH-1:0] res_next;

  assign nib_a  = a_reg[3:0];
  assign nib_nb = ~b_reg[3:0];
  assign gen    = nib_a & nib_nb;
  assign prop   = nib_a ^ nib_nb;

  // Every carry is formed directly from generate/propagate and the carry-in, with no ripple between carries.
  always_comb begin
    carry[0] = ~borrow_reg;
    carry[1] = gen[0] | (prop[0] & carry[0]);
    carry[2] = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & carry[0]);
    carry[3] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
             | (prop[2] & prop[1] & prop[0] & carry[0]);
    carry[4] = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
             | (prop[3] & prop[2] & prop[1] & gen[0])
             | (prop[3] & prop[2] & prop[1] & prop[0] & carry[0]);
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sum
      assign nib_sum[gi] = prop[gi] ^ carry[gi];
    end
  endgenerate

  // Insert the new nibble at the top and shift the partial result down.
  // After NIBBLES cycles, nibble 0 sits in bits [3:0].
  assign res_cat  = {nib_sum, res_reg};
  assign res_next = res_cat[WIDTH+3:4];

  // Control FSM, datapath and registered outputs together.
  // An asynchronous reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      borrow_reg <= 1'b0;
      a_reg      <= '0;
      b_reg      <= '0;
      a_msb_reg  <= 1'b0;
      b_msb_reg  <= 1'b0;
      res_reg    <= '0;
      diff_reg   <= '0;
      bout_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            a_reg      <= bus.a;
            b_reg      <= bus.b;
            a_msb_reg  <= bus.a[WIDTH-1];
            b_msb_reg  <= bus.b[WIDTH-1];
            borrow_reg <= bus.bin;
            cnt_reg    <= '0;
            busy_reg   <= 1'b1;
            state_reg  <= RUN;
          end
        end
        RUN: begin
          a_reg      <= a_reg >> 4;
          b_reg      <= b_reg >> 4;
          res_reg    <= res_next;
          borrow_reg <= ~carry[4];
          cnt_reg    <= cnt_reg + CNT_W'(1);
          if (cnt_reg == LAST_NIB) begin
            diff_reg  <= res_next;
            bout_reg  <= ~carry[4];
            ovf_reg   <= (a_msb_reg != b_msb_reg) && (res_next[WIDTH-1] != a_msb_reg);
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_reg;
  assign bus.done = done_reg;
  assign bus.diff = diff_reg;
  assign bus.bout = bout_reg;
  assign bus.ovf  = ovf_reg;

endmodule
